// File: rtl/maze_tile_renderer.sv
// maze_tile_renderer: raster walker that turns tile-map codes into 24-bit RGB pixels
module maze_tile_renderer #(
    parameter int TILE_PX = 20,
    parameter int COLS    = 32,
    parameter int ROWS    = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       frame_start,
    output logic [9:0] rd_addr,
    input  logic [3:0] rd_data,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       pix_valid,
    output logic [9:0] out_x,
    output logic [8:0] out_y
);
    localparam logic [4:0] SUB_MAX = 5'(TILE_PX - 1);
    localparam logic [9:0] X_MAX   = 10'(TILE_PX * COLS - 1);
    localparam logic [8:0] Y_MAX   = 9'(TILE_PX * ROWS - 1);

    logic [4:0]  sub_x, col, sub_y, row;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [4:0]  cur_sub_x, cur_col, cur_sub_y, cur_row;
    logic [9:0]  cur_x;
    logic [8:0]  cur_y;
    logic [4:0]  n_sub_x, n_col, n_sub_y, n_row;
    logic [9:0]  n_x;
    logic [8:0]  n_y;
    logic        x_wrap, sx_wrap, y_wrap, sy_wrap;
    logic        v1;
    logic [4:0]  s1_sx, s1_sy;
    logic [9:0]  s1_x;
    logic [8:0]  s1_y;
    logic        in_8_11, in_6_13, in_2_17, corner;
    logic [23:0] rgb;

    assign cur_sub_x = frame_start ? '0 : sub_x;
    assign cur_col   = frame_start ? '0 : col;
    assign cur_sub_y = frame_start ? '0 : sub_y;
    assign cur_row   = frame_start ? '0 : row;
    assign cur_x     = frame_start ? '0 : x;
    assign cur_y     = frame_start ? '0 : y;
    assign x_wrap    = cur_x == X_MAX;
    assign sx_wrap   = cur_sub_x == SUB_MAX;
    assign y_wrap    = cur_y == Y_MAX;
    assign sy_wrap   = cur_sub_y == SUB_MAX;
    assign rd_addr   = {cur_row, cur_col};

    // next raster position: hold, or advance one pixel from the (possibly realigned) position
    always_comb begin
        n_sub_x = cur_sub_x;
        n_col   = cur_col;
        n_sub_y = cur_sub_y;
        n_row   = cur_row;
        n_x     = cur_x;
        n_y     = cur_y;
        if (pix_en) begin
            n_x     = x_wrap ? '0 : cur_x + 10'd1;
            n_sub_x = (x_wrap || sx_wrap) ? '0 : cur_sub_x + 5'd1;
            n_col   = x_wrap ? '0 : cur_col + {4'd0, sx_wrap};
            if (x_wrap) begin
                n_y     = y_wrap ? '0 : cur_y + 9'd1;
                n_sub_y = (y_wrap || sy_wrap) ? '0 : cur_sub_y + 5'd1;
                n_row   = y_wrap ? '0 : cur_row + {4'd0, sy_wrap};
            end
        end
    end

    // raster counters
    always_ff @(posedge clk) begin
        if (reset) begin
            sub_x <= '0;
            col   <= '0;
            sub_y <= '0;
            row   <= '0;
            x     <= '0;
            y     <= '0;
        end else begin
            sub_x <= n_sub_x;
            col   <= n_col;
            sub_y <= n_sub_y;
            row   <= n_row;
            x     <= n_x;
            y     <= n_y;
        end
    end

    // stage 1: carry pixel position alongside the RAM read
    always_ff @(posedge clk) begin
        if (reset) begin
            v1    <= 1'b0;
            s1_sx <= '0;
            s1_sy <= '0;
            s1_x  <= '0;
            s1_y  <= '0;
        end else begin
            v1    <= pix_en;
            s1_sx <= cur_sub_x;
            s1_sy <= cur_sub_y;
            s1_x  <= cur_x;
            s1_y  <= cur_y;
        end
    end

    // tile code plus in-tile offset to colour
    always_comb begin
        in_8_11 = s1_sx >= 5'd8 && s1_sx <= 5'd11 && s1_sy >= 5'd8 && s1_sy <= 5'd11;
        in_6_13 = s1_sx >= 5'd6 && s1_sx <= 5'd13 && s1_sy >= 5'd6 && s1_sy <= 5'd13;
        in_2_17 = s1_sx >= 5'd2 && s1_sx <= 5'd17 && s1_sy >= 5'd2 && s1_sy <= 5'd17;
        corner  = (s1_sx inside {5'd2, 5'd3, 5'd16, 5'd17}) && (s1_sy inside {5'd2, 5'd3, 5'd16, 5'd17});
        rgb = rd_data == 4'd0 ? 24'h000000 :
              rd_data == 4'd1 ? 24'h0000FF :
              rd_data == 4'd2 ? (in_8_11 ? 24'hFFFFFF : 24'h000000) :
              rd_data == 4'd3 ? (in_6_13 ? 24'hFFB8AE : 24'h000000) :
              rd_data == 4'd4 ? ((in_2_17 && !corner) ? 24'hFFFF00 : 24'h000000) :
              rd_data == 4'd5 ? (in_2_17 ? 24'hFF0000 : 24'h000000) :
              24'hFF00FF;
    end

    // stage 2: registered pixel outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_valid <= 1'b0;
            {r, g, b} <= '0;
            out_x     <= '0;
            out_y     <= '0;
        end else begin
            pix_valid <= v1;
            {r, g, b} <= rgb;
            out_x     <= s1_x;
            out_y     <= s1_y;
        end
    end
endmodule

// File: tb/tb_maze_tile_renderer.sv
// tb_maze_tile_renderer: directed checks of raster walk, colour map, latency and reset
module tb_maze_tile_renderer;
    logic       clk = 1'b0;
    logic       reset, pix_en, frame_start;
    logic [9:0] rd_addr;
    logic [3:0] rd_data;
    logic [7:0] r, g, b;
    logic       pix_valid;
    logic [9:0] out_x;
    logic [8:0] out_y;

    logic [3:0]  mem [1024];
    logic [23:0] line_rgb [640];
    logic [9:0]  last_x;
    logic [8:0]  last_y;
    int          vcount = 0;
    int          total = 0, bad = 0;
    int          base;

    always #5 clk = ~clk;

    // two tile rows keep a whole frame (640x40) inside the cycle budget
    maze_tile_renderer #(.ROWS(2)) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .frame_start(frame_start),
        .rd_addr(rd_addr), .rd_data(rd_data), .r(r), .g(g), .b(b),
        .pix_valid(pix_valid), .out_x(out_x), .out_y(out_y)
    );

    // synchronous-read tile RAM
    always @(posedge clk) rd_data <= mem[rd_addr];

    // record emitted pixels
    always @(negedge clk) begin
        if (pix_valid) begin
            line_rgb[out_x] <= {r, g, b};
            last_x          <= out_x;
            last_y          <= out_y;
            vcount          <= vcount + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic en, input logic fs);
        @(negedge clk);
        pix_en      = en;
        frame_start = fs;
        #1;
    endtask

    int          xs [16] = '{0, 1, 2, 10, 17, 18, 19, 20, 27, 28, 31, 32, 45, 46, 53, 60};
    logic [23:0] es [16] = '{24'h000000, 24'h000000, 24'hFFFF00, 24'hFFFF00, 24'hFFFF00, 24'h000000,
                             24'h000000, 24'h000000, 24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000,
                             24'h000000, 24'hFFB8AE, 24'hFFB8AE, 24'hFF00FF};

    initial begin
        reset = 1'b1;
        pix_en = 1'b1;
        frame_start = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 4'd0;
        mem[0] = 4'd1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_valid", {31'd0, pix_valid}, 0);
            chk("rst_addr", {22'd0, rd_addr}, 0);
        end
        drive(1, 0);
        reset = 1'b0;
        chk("p1_addr", {22'd0, rd_addr}, 0);
        drive(0, 0);
        chk("p1_lat1", {31'd0, pix_valid}, 0);
        drive(0, 0);
        chk("p1_valid", {31'd0, pix_valid}, 1);
        chk("p1_x", {22'd0, out_x}, 0);
        chk("p1_y", {23'd0, out_y}, 0);
        chk("p1_rgb", {8'd0, r, g, b}, 32'h0000FF);

        mem[1] = 4'd2;
        base = vcount;
        for (int i = 0; i < 40; i++) begin
            drive(1, i == 0);
            if (i == 0 || i == 19 || i == 20 || i == 39)
                chk("row0_addr", {22'd0, rd_addr}, i < 20 ? 0 : 1);
        end
        drive(0, 0);
        repeat (4) @(negedge clk);
        chk("row0_cnt", vcount - base, 40);
        chk("row0_wall", {8'd0, line_rgb[5]}, 32'h0000FF);
        chk("row0_t1", {8'd0, line_rgb[25]}, 0);
        for (int i = 28; i < 32; i++) chk("row0_pel", {8'd0, line_rgb[i]}, 0);

        mem[0] = 4'd4;
        mem[2] = 4'd3;
        mem[3] = 4'd6;
        for (int i = 0; i < 8 * 640; i++) drive(1, i == 0);
        for (int i = 0; i < 80; i++) drive(1, 0);
        drive(0, 0);
        repeat (4) @(negedge clk);
        chk("y8_last_x", {22'd0, last_x}, 79);
        chk("y8_last_y", {23'd0, last_y}, 8);
        for (int i = 0; i < 16; i++) chk($sformatf("y8_x%0d", xs[i]), {8'd0, line_rgb[xs[i]]}, {8'd0, es[i]});

        for (int i = 0; i < 25600; i++) begin
            drive(1, i == 0);
            if (i == 12799) chk("l19_end_addr", {22'd0, rd_addr}, 31);
            if (i == 12800) chk("l20_addr", {22'd0, rd_addr}, 32);
            if (i == 25599) chk("last_addr", {22'd0, rd_addr}, 63);
        end
        drive(0, 0);
        repeat (4) @(negedge clk);
        chk("last_x", {22'd0, last_x}, 639);
        chk("last_y", {23'd0, last_y}, 39);
        drive(1, 0);
        chk("wrap_addr", {22'd0, rd_addr}, 0);
        drive(0, 0);
        repeat (4) @(negedge clk);
        chk("wrap_x", {22'd0, last_x}, 0);
        chk("wrap_y", {23'd0, last_y}, 0);

        base = vcount;
        for (int k = 0; k < 14; k++) begin
            drive(k < 10 && k % 2 == 0, k == 0);
            if (k >= 2) begin
                chk("alt_valid", {31'd0, pix_valid}, (k < 12 && k % 2 == 0) ? 1 : 0);
                if (pix_valid) chk("alt_x", {22'd0, out_x}, (k - 2) / 2);
            end
        end
        chk("alt_cnt", vcount - base, 5);

        drive(1, 1);
        drive(0, 0);
        reset = 1'b1;
        base = vcount;
        drive(0, 0);
        chk("rst_drop0", {31'd0, pix_valid}, 0);
        reset = 1'b0;
        drive(0, 0);
        chk("rst_drop1", {31'd0, pix_valid}, 0);
        drive(1, 0);
        chk("post_rst_addr", {22'd0, rd_addr}, 0);
        drive(0, 0);
        drive(0, 0);
        chk("post_rst_valid", {31'd0, pix_valid}, 1);
        chk("post_rst_x", {22'd0, out_x}, 0);
        chk("post_rst_y", {23'd0, out_y}, 0);
        chk("post_rst_rgb", {8'd0, r, g, b}, 0);
        repeat (3) @(negedge clk);
        chk("post_rst_cnt", vcount - base, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/maze_tile_renderer.md
Name: maze_tile_renderer

Overview:
- Downstream consumer of the 1024x4 tile map that the Pac-Man position updater writes (write_addr/write_data/wren).
- Reads that map through the RAM's second, read-only port and turns each tile code into 24-bit RGB pixels for the VGA output stage.
- Generates its own raster position, advancing one pixel per pix_en strobe from the VGA timing driver, over a 640x480 active area.
- Uses a 32x24 grid of 20x20-pixel tiles.

Parameters:
- TILE_PX, 20, tile edge in pixels.
- COLS, 32, tiles per row (power of two; address = row*COLS+col).
- ROWS, 24, tile rows per frame.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pix_en  in  1  one active pixel requested this cycle.
- frame_start  in  1  single-cycle pulse; realigns raster to (0,0).
- rd_addr  out  10  tile map read address, combinational from the current tile counters.
- rd_data  in  4  tile code; valid one cycle after rd_addr is presented (synchronous RAM).
- r  out  8  red.
- g  out  8  green.
- b  out  8  blue.
- pix_valid  out  1  r/g/b/out_x/out_y are valid this cycle.
- out_x  out  10  column of the emitted pixel, 0..639.
- out_y  out  9  row of the emitted pixel, 0..479.

Behaviour:
- Raster state: sub_x 0..TILE_PX-1, col 0..COLS-1, sub_y 0..TILE_PX-1, row 0..ROWS-1, plus x 0..639 and y 0..479 kept as separate counters; no dividers.
- rd_addr = {row[4:0], col[4:0]}. Max address is 767; addresses 768..1023 are never read.
- Advance on pix_en: increment sub_x and x.
  - sub_x wrap 19->0 increments col.
  - x wrap 639->0 also clears col and sub_x, and increments sub_y/y.
  - sub_y wrap 19->0 increments row.
  - y wrap 479->0 clears row and sub_y (frame wrap).
- Counters hold when pix_en=0.
- frame_start: counters are treated as (0,0) that cycle.
  - If pix_en=1 in the same cycle, pixel (0,0) is consumed and counters become (1,0).
  - Otherwise counters are set to (0,0).
- Pipeline:
  - Stage 1 (cycle N, pix_en=1): rd_addr presented; register v1, sub_x, sub_y, x, y.
  - Stage 2 (cycle N+1): rd_data valid; compute colour, register to outputs.
  - pix_valid=1 in cycle N+2. Fixed latency 2; the pipeline advances every clock regardless of pix_en.
  - Back-to-back pix_en gives back-to-back pix_valid with no bubbles.
- Colour map, with sx/sy = delayed sub_x/sub_y; "else" means black 000000:
  - 0: empty, 000000.
  - 1: wall, 0000FF over the whole tile.
  - 2: pellet, FFFFFF if sx,sy both in 8..11, else black.
  - 3: power pellet, FFB8AE if sx,sy both in 6..13, else black.
  - 4: Pac-Man, FFFF00 if sx,sy both in 2..17 and not in a trimmed 2x2 corner (sx in {2,3} or {16,17}, and sy in {2,3} or {16,17}), else black.
  - 5: ghost, FF0000 if sx,sy both in 2..17, else black.
  - 6..15: FF00FF over the whole tile (undefined-code debug marker).
- Reset, including mid-frame:
  - Counters and rd_addr go to 0.
  - r/g/b/out_x/out_y go to 0 and pix_valid to 0.
  - Pipeline valid bits are cleared, so in-flight pixels are dropped and never emitted.
  - pix_en during reset is ignored.

Test Plan:
- Reset for 2 cycles, then 1 pix_en, with RAM[0]=1 -> pix_valid=0 during reset; 2 cycles after pix_en: pix_valid=1, out_x=0, out_y=0, rgb=0000FF.
- RAM[1]=2; pulse frame_start, then 40 consecutive pix_en -> rd_addr=0 for pixels 0..19 and 1 for pixels 20..39. Pixels x=28..31 on y=0 are black, since the pellet lies only in rows 8..11.
- Raster to y=8 (8*640 pix_en), then 20 more pix_en with RAM[0]=4, then 20 with RAM[1]=2 -> tile 0: x=0,1 black, x=2..17 FFFF00 (row 8 is outside the trimmed corners), x=18,19 black. Tile 1: x=28..31 FFFFFF, rest black.
- Raster to end of line 19 (x=639,y=19), then 1 pix_en -> next rd_addr=32 (row 1, col 0). Last pixel of frame (639,479): rd_addr=767, then wraps to 0 with out_y back to 0.
- Alternate pix_en 1/0 for 10 cycles -> exactly 5 pix_valid pulses, each 2 cycles after its pix_en; out_x runs 0..4.
- Assert reset one cycle after pix_en -> no pix_valid emitted for that pixel. The next pix_en after release reads rd_addr=0 and emits (0,0).
